// File: rtl/alu_cmp_arbiter_pkg.sv
// Shared types for the compare arbiter: compare opcodes, FSM states, ALU flag bundle.
package alu_cmp_arbiter_pkg;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'd0,
    CMP_NE  = 2'd1,
    CMP_LT  = 2'd2,
    CMP_LTU = 2'd3
  } cmp_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned ALU_LAT_MAX = 4;
  localparam int unsigned CNT_W       = 2;

  typedef struct packed {
    logic msb;
    logic cout;
    logic zero;
    logic ovf;
  } alu_flags_t;

endpackage

// File: rtl/alu_cmp_arbiter_if.sv
// Request/response and ALU-side signal bundle; slave = arbiter view, master = environment view.
interface alu_cmp_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  import alu_cmp_arbiter_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  cmp_op_t          req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  cmp_op_t          req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp0_true;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic             rsp1_true;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_sub;
  logic             alu_start;
  logic             alu_msb;
  logic             alu_cout;
  logic             alu_zero;
  logic             alu_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_true, rsp1_valid, rsp1_true,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_sub, alu_start,
    input  alu_msb, alu_cout, alu_zero, alu_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_true, rsp1_valid, rsp1_true,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_sub, alu_start,
    output alu_msb, alu_cout, alu_zero, alu_ovf
  );

endinterface

// File: rtl/alu_cmp_arbiter_cmp_outcome.sv
// cmp_outcome: turns subtract-mode ALU flags plus a compare opcode into a single outcome bit.
module alu_cmp_arbiter_cmp_outcome
  import alu_cmp_arbiter_pkg::*;
(
  input  alu_flags_t flags,
  input  cmp_op_t    op,
  output logic       outcome_c
);

  logic eql;
  logic slts;
  logic sltu;

  always_comb begin
    eql       = flags.zero;
    slts      = flags.ovf ^ flags.msb;
    sltu      = ~flags.cout;
    outcome_c = eql;
    case (op)
      CMP_EQ:  outcome_c = eql;
      CMP_NE:  outcome_c = ~eql;
      CMP_LT:  outcome_c = slts;
      CMP_LTU: outcome_c = sltu;
      default: outcome_c = eql;
    endcase
  end

endmodule

// File: rtl/alu_cmp_arbiter.sv
// Shares one subtract-mode ALU between two compare requesters and returns a 1-bit outcome.
// Define CMP_RR_ARB_EN for round-robin arbitration; otherwise req0 has fixed priority.
module alu_cmp_arbiter
  import alu_cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_cmp_arbiter_if.slave   bus,
  output logic               busy
);

  localparam int unsigned CNT_INIT = ALU_LAT - 1;

  if (ALU_LAT < 1 || ALU_LAT > ALU_LAT_MAX) begin : g_lat_chk
    $error("alu_cmp_arbiter: ALU_LAT out of range");
  end

  state_t           state;
  state_t           state_n;
  logic             any_valid_c;
  logic             grant_c;
  logic             win_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  cmp_op_t          sel_op_c;
  logic             winner;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  cmp_op_t          op_q;
  logic [CNT_W-1:0] cnt;
  logic             outcome_q;
  logic             outcome_c;
  logic             outcome_n;
  logic             rsp_taken_c;
  logic             drive_n;
  logic             start_n;
  logic             rsp_n;
  alu_flags_t       flags_c;

  // Grants only from IDLE, and never while reset is asserted.
  assign any_valid_c = bus.req0_valid | bus.req1_valid;
  assign grant_c     = rst_n & (state == IDLE) & any_valid_c;

`ifdef CMP_RR_ARB_EN
  logic ptr;

  // Pointer names the preferred requester; it moves to the loser after each grant.
  assign win_c = ptr ? bus.req1_valid : ~bus.req0_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant_c) begin
      ptr <= ~win_c;
    end
  end
`else
  assign win_c = ~bus.req0_valid;
`endif

  assign bus.req0_ready = grant_c & ~win_c;
  assign bus.req1_ready = grant_c & win_c;

  assign sel_a_c  = win_c ? bus.req1_a  : bus.req0_a;
  assign sel_b_c  = win_c ? bus.req1_b  : bus.req0_b;
  assign sel_op_c = win_c ? bus.req1_op : bus.req0_op;

  always_comb begin
    flags_c.msb  = bus.alu_msb;
    flags_c.cout = bus.alu_cout;
    flags_c.zero = bus.alu_zero;
    flags_c.ovf  = bus.alu_ovf;
  end

  alu_cmp_arbiter_cmp_outcome u_outcome (
    .flags     (flags_c),
    .op        (op_q),
    .outcome_c (outcome_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state plus the next values of the registered outputs.
  always_comb begin
    state_n     = state;
    rsp_taken_c = winner ? bus.rsp1_ready : bus.rsp0_ready;
    case (state)
      IDLE:    if (grant_c) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (cnt == '0) state_n = RESP;
      RESP:    if (rsp_taken_c) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    drive_n   = (state_n == ISSUE) || (state_n == WAIT);
    start_n   = (state_n == ISSUE);
    rsp_n     = (state_n == RESP);
    outcome_n = (state == WAIT) ? outcome_c : outcome_q;
  end

  // Latched request, latency counter and outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= CMP_EQ;
      cnt       <= '0;
      outcome_q <= 1'b0;
    end else begin
      if (grant_c) begin
        winner <= win_c;
        a_q    <= sel_a_c;
        b_q    <= sel_b_c;
        op_q   <= sel_op_c;
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(CNT_INIT);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == WAIT && cnt == '0) begin
        outcome_q <= outcome_c;
      end
    end
  end

  // Registered outputs; ALU operands are forced to zero outside ISSUE/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_sub    <= 1'b0;
      bus.alu_start  <= 1'b0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_true  <= 1'b0;
      bus.rsp1_true  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      bus.alu_a      <= drive_n ? (grant_c ? sel_a_c : a_q) : '0;
      bus.alu_b      <= drive_n ? (grant_c ? sel_b_c : b_q) : '0;
      bus.alu_sub    <= drive_n;
      bus.alu_start  <= start_n;
      bus.rsp0_valid <= rsp_n & ~winner;
      bus.rsp1_valid <= rsp_n & winner;
      bus.rsp0_true  <= rsp_n & ~winner & outcome_n;
      bus.rsp1_true  <= rsp_n & winner & outcome_n;
      busy           <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_cmp_arbiter.sv
// Scoreboard bench for alu_cmp_arbiter: ALU_LAT=1 instance for most vectors, ALU_LAT=4 for the long-latency case.
module tb_alu_cmp_arbiter;
  import alu_cmp_arbiter_pkg::*;

  typedef struct {
    int   inst;
    int   port;
    logic tru;
    int   cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy_a;
  logic busy_b;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  bit   active [2];
  logic held   [2];
`ifdef CMP_RR_ARB_EN
  int   ptr_m = 0;
`endif

  alu_cmp_arbiter_if #(.WIDTH(32)) ia ();
  alu_cmp_arbiter_if #(.WIDTH(32)) ib ();

  alu_cmp_arbiter #(.WIDTH(32), .ALU_LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a)
  );

  alu_cmp_arbiter #(.WIDTH(32), .ALU_LAT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference subtract ALU: flags are only correct exactly LAT cycles after alu_start.
  function automatic alu_flags_t calc(input logic [31:0] a, input logic [31:0] b);
    alu_flags_t  f;
    logic [32:0] s;
    s      = {1'b0, a} + {1'b0, ~b} + 33'd1;
    f.cout = s[32];
    f.msb  = s[31];
    f.zero = (s[31:0] == 32'd0);
    f.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
    return f;
  endfunction

  alu_flags_t fl_a = '0;
  alu_flags_t fl_b = '0;
  int k_a = 0;
  int k_b = 0;

  always @(posedge clk) begin
    if (ia.alu_start) begin
      fl_a <= calc(ia.alu_a, ia.alu_b);
      k_a  <= 1;
    end else if (k_a > 0 && k_a < 1000) k_a <= k_a + 1;
    if (ib.alu_start) begin
      fl_b <= calc(ib.alu_a, ib.alu_b);
      k_b  <= 1;
    end else if (k_b > 0 && k_b < 1000) k_b <= k_b + 1;
  end

  assign ia.alu_msb  = (k_a == 1) ? fl_a.msb  : ~fl_a.msb;
  assign ia.alu_cout = (k_a == 1) ? fl_a.cout : ~fl_a.cout;
  assign ia.alu_zero = (k_a == 1) ? fl_a.zero : ~fl_a.zero;
  assign ia.alu_ovf  = (k_a == 1) ? fl_a.ovf  : ~fl_a.ovf;
  assign ib.alu_msb  = (k_b == 4) ? fl_b.msb  : ~fl_b.msb;
  assign ib.alu_cout = (k_b == 4) ? fl_b.cout : ~fl_b.cout;
  assign ib.alu_zero = (k_b == 4) ? fl_b.zero : ~fl_b.zero;
  assign ib.alu_ovf  = (k_b == 4) ? fl_b.ovf  : ~fl_b.ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [1:0] m);
    if (m == 2'b10) return 1;
    if (m == 2'b01) return 0;
`ifdef CMP_RR_ARB_EN
    return ptr_m;
`else
    return 0;
`endif
  endfunction

  // Monitor step for one instance: check a new response against the head, then stability, pop on handshake.
  task automatic mon(input int inst, input logic v0, input logic v1, input logic t0,
                     input logic t1, input logic r0, input logic r1);
    int   p;
    logic t;
    logic r;
    exp_t e;
    if (!(v0 || v1)) begin
      active[inst] = 1'b0;
      return;
    end
    if (v0 && v1) chk("rsp_onehot", {30'd0, v1, v0}, 32'd1);
    p = v1 ? 1 : 0;
    t = v1 ? t1 : t0;
    r = v1 ? r1 : r0;
    if (!active[inst]) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected_queue_len", 32'(q.size()), 32'd1);
      end else begin
        e = q[0];
        chk("rsp_inst", 32'(inst), 32'(e.inst));
        chk("rsp_port", 32'(p), 32'(e.port));
        chk("rsp_true", {31'd0, t}, {31'd0, e.tru});
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
      active[inst] = 1'b1;
      held[inst]   = t;
    end else begin
      chk("rsp_stable", {31'd0, t}, {31'd0, held[inst]});
    end
    if (r) begin
      if (q.size() > 0) void'(q.pop_front());
      active[inst] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ia.rsp0_valid, ia.rsp1_valid, ia.rsp0_true, ia.rsp1_true, ia.rsp0_ready, ia.rsp1_ready);
      mon(1, ib.rsp0_valid, ib.rsp1_valid, ib.rsp0_true, ib.rsp1_true, ib.rsp0_ready, ib.rsp1_ready);
    end
  end

  // Present a request pattern on instance A, wait for the grant, push the expected response.
  task automatic issue(input logic [1:0] mask,
                       input cmp_op_t op0, input logic [31:0] a0, input logic [31:0] b0, input logic t0,
                       input cmp_op_t op1, input logic [31:0] a1, input logic [31:0] b1, input logic t1);
    int   wp;
    int   t;
    bit   got;
    exp_t e;
    ia.req0_op = op0; ia.req0_a = a0; ia.req0_b = b0;
    ia.req1_op = op1; ia.req1_a = a1; ia.req1_b = b1;
    ia.req0_valid = mask[0];
    ia.req1_valid = mask[1];
    wp  = pick(mask);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (ia.req0_ready || ia.req1_ready) got = 1'b1;
    end
    chk("grant_seen", {31'd0, got}, 32'd1);
    if (got) begin
      chk("grant_port", {31'd0, ia.req1_ready}, 32'(wp));
      t = cyc;
      e = '{inst: 0, port: wp, tru: (wp == 1) ? t1 : t0, cyc: t + 3};
      q.push_back(e);
`ifdef CMP_RR_ARB_EN
      ptr_m = (wp == 0) ? 1 : 0;
`endif
      @(posedge clk); #1;
      ia.req0_valid = 1'b0;
      ia.req1_valid = 1'b0;
      chk("alu_start", {31'd0, ia.alu_start}, 32'd1);
      chk("alu_sub", {31'd0, ia.alu_sub}, 32'd1);
      chk("alu_a", ia.alu_a, (wp == 1) ? a1 : a0);
      chk("alu_b", ia.alu_b, (wp == 1) ? b1 : b0);
    end else begin
      ia.req0_valid = 1'b0;
      ia.req1_valid = 1'b0;
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue_len", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   got;
    exp_t e;
    rst_n = 1'b0;
    ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
    ia.req0_a = '0; ia.req0_b = '0; ia.req0_op = CMP_EQ;
    ia.req1_a = '0; ia.req1_b = '0; ia.req1_op = CMP_EQ;
    ia.rsp0_ready = 1'b1; ia.rsp1_ready = 1'b1;
    ib.req0_valid = 1'b0; ib.req1_valid = 1'b0;
    ib.req0_a = '0; ib.req0_b = '0; ib.req0_op = CMP_EQ;
    ib.req1_a = '0; ib.req1_b = '0; ib.req1_op = CMP_EQ;
    ib.rsp0_ready = 1'b1; ib.rsp1_ready = 1'b1;
    #3;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_alu_start", {31'd0, ia.alu_start}, 32'd0);
    chk("rst_alu_a", ia.alu_a, 32'd0);
    chk("rst_rsp_valid", {30'd0, ia.rsp1_valid, ia.rsp0_valid}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // EQ 5,5 on req0; latency checked by the monitor.
    issue(2'b01, CMP_EQ, 32'd5, 32'd5, 1'b1, CMP_EQ, 32'd0, 32'd0, 1'b0);
    // Signed vs unsigned less-than of -1 and 1 on req1.
    issue(2'b10, CMP_EQ, 32'd0, 32'd0, 1'b0, CMP_LT,  32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(2'b10, CMP_EQ, 32'd0, 32'd0, 1'b0, CMP_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0);
    drain();

    // Both requesters valid together, four times.
    for (int i = 0; i < 4; i++) begin
      issue(2'b11, CMP_EQ, 32'd7, 32'd7, 1'b1, CMP_EQ, 32'd7, 32'd8, 1'b0);
    end
    drain();

    // Response back-pressure on req0 while req1 waits.
    ia.rsp0_ready = 1'b0;
    issue(2'b01, CMP_NE, 32'd3, 32'd4, 1'b1, CMP_EQ, 32'd0, 32'd0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ia.rsp0_valid) got = 1'b1;
    end
    chk("hold_rsp_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    ia.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req0_ready", {31'd0, ia.req0_ready}, 32'd0);
      chk("hold_req1_ready", {31'd0, ia.req1_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy_a}, 32'd1);
      chk("hold_rsp0_valid", {31'd0, ia.rsp0_valid}, 32'd1);
      chk("hold_rsp0_true", {31'd0, ia.rsp0_true}, 32'd1);
    end
    @(posedge clk); #1;
    ia.req1_valid = 1'b0;
    ia.rsp0_ready = 1'b1;
    drain();

    // Reset asserted during WAIT aborts the operation.
    issue(2'b01, CMP_EQ, 32'd1, 32'd2, 1'b0, CMP_EQ, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("wait_busy", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_alu_sub", {31'd0, ia.alu_sub}, 32'd0);
    chk("abort_alu_a", ia.alu_a, 32'd0);
    chk("abort_rsp_valid", {30'd0, ia.rsp1_valid, ia.rsp0_valid}, 32'd0);
    if (q.size() > 0) void'(q.pop_back());
`ifdef CMP_RR_ARB_EN
    ptr_m = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale_rsp", {30'd0, ia.rsp1_valid, ia.rsp0_valid}, 32'd0);
    issue(2'b11, CMP_EQ, 32'd9, 32'd9, 1'b1, CMP_NE, 32'd9, 32'd9, 1'b0);
    drain();

    // Long-latency instance: overflow case of signed LT, then unsigned LT on the same operands.
    for (int v = 0; v < 2; v++) begin
      ib.req0_op    = (v == 0) ? CMP_LT : CMP_LTU;
      ib.req0_a     = 32'h7FFF_FFFF;
      ib.req0_b     = 32'hFFFF_FFFF;
      ib.req0_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (ib.req0_ready) got = 1'b1;
      end
      chk("b_grant_seen", {31'd0, got}, 32'd1);
      if (got) begin
        e = '{inst: 1, port: 0, tru: (v == 0) ? 1'b0 : 1'b1, cyc: cyc + 6};
        q.push_back(e);
      end
      @(posedge clk); #1;
      ib.req0_valid = 1'b0;
      drain();
    end

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
